// File: rtl/wb_queue_if.sv
// Writeback-queue bus: two exec-lane push ports in, flush/hold control, and
// two registered register-file write ports plus lane status out.
interface wb_queue_if #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 16
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              flush_i;
   logic              hold_i;
   logic              pushA_i;
   logic              pushB_i;
   logic [4:0]        addrA_i;
   logic [4:0]        addrB_i;
   logic [DATA_W-1:0] valA_i;
   logic [DATA_W-1:0] valB_i;
   logic [1:0]        statusA_i;
   logic [1:0]        statusB_i;
   logic              fullA_o;
   logic              fullB_o;
   logic              overflowA_o;
   logic              overflowB_o;
   logic [CNT_W-1:0]  countA_o;
   logic [CNT_W-1:0]  countB_o;
   logic              wbA_o;
   logic              wbB_o;
   logic [4:0]        wbAddrA_o;
   logic [4:0]        wbAddrB_o;
   logic [DATA_W-1:0] wbValA_o;
   logic [DATA_W-1:0] wbValB_o;
   logic [1:0]        operationStatusA_o;
   logic [1:0]        operationStatusB_o;

   modport master (
      output flush_i, hold_i, pushA_i, pushB_i, addrA_i, addrB_i,
             valA_i, valB_i, statusA_i, statusB_i,
      input  fullA_o, fullB_o, overflowA_o, overflowB_o, countA_o, countB_o,
             wbA_o, wbB_o, wbAddrA_o, wbAddrB_o, wbValA_o, wbValB_o,
             operationStatusA_o, operationStatusB_o
   );

   modport slave (
      input  flush_i, hold_i, pushA_i, pushB_i, addrA_i, addrB_i,
             valA_i, valB_i, statusA_i, statusB_i,
      output fullA_o, fullB_o, overflowA_o, overflowB_o, countA_o, countB_o,
             wbA_o, wbB_o, wbAddrA_o, wbAddrB_o, wbValA_o, wbValB_o,
             operationStatusA_o, operationStatusB_o
   );
endinterface

// File: rtl/wb_queue.sv
// Two-lane writeback queue: per-lane circular FIFO feeding registered
// register-file write ports, with same-address ordering between lanes.
module wb_queue #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 16
) (
   input logic        clock_i,
   input logic        reset_i,
   wb_queue_if.slave  bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = 5 + DATA_W + 2;

   logic [ENT_W-1:0] r_mem   [2][DEPTH];
   logic [PTR_W-1:0] r_rptr  [2];
   logic [PTR_W-1:0] r_wptr  [2];
   logic [CNT_W-1:0] r_cnt   [2];
   logic             r_ovf   [2];
   logic             r_wb    [2];
   logic [ENT_W-1:0] r_wbEnt [2];

   logic             w_push    [2];
   logic [ENT_W-1:0] w_in      [2];
   logic [ENT_W-1:0] w_head    [2];
   logic             w_headVld [2];
   logic             w_full    [2];
   logic             w_accept  [2];
   logic             w_pop     [2];
   logic             w_collide;

   // An empty lane's head is the incoming push, so an accepted push can be
   // written and popped in the same cycle for 1-cycle latency.
   always_comb begin
      w_push[0] = bus.pushA_i;
      w_push[1] = bus.pushB_i;
      w_in[0]   = {bus.addrA_i, bus.valA_i, bus.statusA_i};
      w_in[1]   = {bus.addrB_i, bus.valB_i, bus.statusB_i};
      for (int l = 0; l < 2; l++) begin
         w_full[l]    = (r_cnt[l] == CNT_W'(DEPTH));
         w_accept[l]  = w_push[l] && !w_full[l] && !bus.flush_i;
         w_headVld[l] = (r_cnt[l] != '0) || w_push[l];
         w_head[l]    = (r_cnt[l] != '0) ? r_mem[l][r_rptr[l]] : w_in[l];
      end
      w_collide = w_headVld[0] && w_headVld[1] &&
                  (w_head[0][ENT_W-1 -: 5] == w_head[1][ENT_W-1 -: 5]);
      w_pop[0]  = !bus.flush_i && !bus.hold_i && w_headVld[0];
      w_pop[1]  = !bus.flush_i && !bus.hold_i && w_headVld[1] && !w_collide;
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         for (int l = 0; l < 2; l++) begin
            r_rptr[l]  <= '0;
            r_wptr[l]  <= '0;
            r_cnt[l]   <= '0;
            r_ovf[l]   <= 1'b0;
            r_wb[l]    <= 1'b0;
            r_wbEnt[l] <= '0;
         end
      end else begin
         for (int l = 0; l < 2; l++) begin
            if (bus.flush_i) begin
               r_rptr[l] <= '0;
               r_wptr[l] <= '0;
               r_cnt[l]  <= '0;
               r_ovf[l]  <= 1'b0;
               r_wb[l]   <= 1'b0;
            end else begin
               if (w_accept[l]) r_wptr[l] <= r_wptr[l] + PTR_W'(1);
               if (w_pop[l])    r_rptr[l] <= r_rptr[l] + PTR_W'(1);
               r_cnt[l] <= r_cnt[l] + CNT_W'(w_accept[l]) - CNT_W'(w_pop[l]);
               if (w_push[l] && w_full[l]) r_ovf[l] <= 1'b1;
               r_wb[l] <= w_pop[l];
               if (w_pop[l]) r_wbEnt[l] <= w_head[l];
            end
         end
      end
   end

   always_ff @(posedge clock_i) begin
      for (int l = 0; l < 2; l++) begin
         if (w_accept[l]) r_mem[l][r_wptr[l]] <= w_in[l];
      end
   end

   assign bus.fullA_o     = w_full[0];
   assign bus.fullB_o     = w_full[1];
   assign bus.countA_o    = r_cnt[0];
   assign bus.countB_o    = r_cnt[1];
   assign bus.overflowA_o = r_ovf[0];
   assign bus.overflowB_o = r_ovf[1];
   assign bus.wbA_o       = r_wb[0];
   assign bus.wbB_o       = r_wb[1];
   assign {bus.wbAddrA_o, bus.wbValA_o, bus.operationStatusA_o} = r_wbEnt[0];
   assign {bus.wbAddrB_o, bus.wbValB_o, bus.operationStatusB_o} = r_wbEnt[1];
endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, entries per lane (power of two, 2..16).
REQ-002 SHALL have parameter DATA_W, default 16, writeback value width.
REQ-003 SHALL have port clock_i, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset_i, input, 1, reset; asynchronous and active-high.
REQ-005 SHALL have port flush_i, input, 1, discard all queued writebacks (branch/flushBack).
REQ-006 SHALL have port hold_i, input, 1, suppress all pops this cycle.
REQ-007 SHALL have ports pushA_i/pushB_i, input, 1, exec lane A/B result valid.
REQ-008 SHALL have ports addrA_i/addrB_i, input, 5, destination register.
REQ-009 SHALL have ports valA_i/valB_i, input, DATA_W, result value.
REQ-010 SHALL have ports statusA_i/statusB_i, input, 2, overflow (bit 1) and underflow (bit 0) flags.
REQ-011 SHALL have ports fullA_o/fullB_o, output, 1, lane holds DEPTH entries.
REQ-012 SHALL have ports overflowA_o/overflowB_o, output, 1, sticky: a push was dropped.
REQ-013 SHALL have ports countA_o/countB_o, output, log2(DEPTH)+1, entries held.
REQ-014 SHALL have ports wbA_o/wbB_o, output, 1, register-file write enable toward the register controller.
REQ-015 SHALL have ports wbAddrA_o/wbAddrB_o (5), wbValA_o/wbValB_o (DATA_W), operationStatusA_o/operationStatusB_o (2), outputs, write payload.

Function
REQ-016 SHALL keep an independent circular FIFO per lane: read pointer, write pointer and count, with pointers wrapping modulo DEPTH.
REQ-017 SHALL enqueue {addr, val, status} on pushX_i when countX < DEPTH, evaluated on the pre-edge count; pushes are never accepted on the strength of a same-cycle pop.
REQ-018 SHALL drop a push made while full, leave the FIFO unchanged, and set overflowX_o until reset or flush.
REQ-019 SHALL make all wb* outputs registered; a push into an empty lane with no hold produces wbX_o=1 on the next cycle, giving 1-cycle minimum latency.
REQ-020 SHALL pop each non-empty lane at most once per cycle when hold_i=0, driving the head entry onto the lane's wb outputs the following cycle with wbX_o=1.
REQ-021 SHALL pop only lane A when both heads are valid and have equal addresses, leaving lane B's head for a later cycle, so B (younger in program order) writes last.
REQ-022 SHALL drive wbX_o=0 in the following cycle for any lane not popped; address, value and status hold their last values.
REQ-023 SHALL allow push and pop on a lane in the same cycle when non-full; the count is then unchanged and FIFO order is preserved.
REQ-024 SHALL, on flush_i=1, zero pointers and counts, clear overflow flags, drive wbA_o=wbB_o=0 next cycle, and ignore same-cycle pushes; flush has priority over hold and push.
REQ-025 SHALL, on hold_i=1, pop nothing, drive wbA_o=wbB_o=0 next cycle, and still accept pushes.
REQ-026 SHALL compute fullX_o and countX_o combinationally from the registered count.

Reset
REQ-027 SHALL, while reset_i=1, asynchronously force pointers, counts, overflow flags, wbA_o, wbB_o, wbAddr*, wbVal* and operationStatus* to 0.
REQ-028 SHALL begin accepting pushes on the first rising edge after reset_i deasserts.

Verification
REQ-029 SHALL cover single push: pushA addr=3 val=0x1234 status=2'b10 on an empty lane -> next cycle wbA_o=1, wbAddrA_o=3, wbValA_o=0x1234, operationStatusA_o=2'b10; the cycle after, wbA_o=0.
REQ-030 SHALL cover fill and overflow: hold_i=1, 5 pushes on lane B with DEPTH=4 -> fullB_o=1, countB_o=4, overflowB_o=1; release hold -> 4 writes in push order, 5th absent.
REQ-031 SHALL cover collision: A head addr=7 val=0xAAAA, B head addr=7 val=0xBBBB -> cycle 1 only wbA_o=1 (0xAAAA); cycle 2 wbB_o=1 (0xBBBB).
REQ-032 SHALL cover wrap-around: 10 interleaved push/pop operations on lane A, values 1..10 -> outputs 1..10 in order with no loss.
REQ-033 SHALL cover flush: 3 entries per lane, flush_i plus a same-cycle pushA -> next cycle wbA_o=wbB_o=0, counts 0, overflow cleared.
REQ-034 SHALL cover asynchronous reset: reset_i asserted mid-cycle with entries queued -> outputs 0 before the next edge; queue empty after release.
